// File: rtl/bi_pkg.sv
// Shared types and helpers for the bit-interleaved rotate-left unit.
package bi_pkg;

    localparam int LANE_W  = 64;
    localparam int HALF_W  = 32;
    localparam int SHIFT_W = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC_E = 2'd1,
        CALC_O = 2'd2,
        DONE   = 2'd3
    } bi_state_t;

    // Interleaved lane: odd natural bits in the upper word, even in the lower.
    typedef struct packed {
        logic [HALF_W-1:0] odd;
        logic [HALF_W-1:0] even;
    } bi_lane_t;

    // Per-half rotator setup: which source word to rotate and by how much.
    typedef struct packed {
        logic       src_odd;
        logic [4:0] amt;
    } bi_half_cfg_t;

    // A natural rotate by n moves whole word pairs by k = n>>1. An odd n also
    // swaps the words; bits that leave the top of the odd word re-enter the
    // even word one position further on, hence k+1 (5-bit wrap gives mod 32).
    function automatic bi_half_cfg_t bi_half_cfg(input logic [SHIFT_W-1:0] n,
                                                 input logic               odd_half);
        bi_half_cfg_t c;
        if (odd_half) begin
            c.src_odd = ~n[0];
            c.amt     = n[5:1];
        end else begin
            c.src_odd = n[0];
            c.amt     = n[5:1] + {4'd0, n[0]};
        end
        return c;
    endfunction

endpackage

// File: rtl/bi_rotl32.sv
// Combinational 32-bit barrel rotate-left.
module bi_rotl32 (
    input  logic [31:0] din,
    input  logic [4:0]  amt,
    output logic [31:0] dout
);

    logic [63:0] dbl;

    // Upper word of the shifted doubled value is the rotated word.
    always_comb begin
        dbl  = {din, din} << amt;
        dout = dbl[63:32];
    end

endmodule

// File: rtl/bi_rotl_seq.sv
// Sequential rotate-left of a bit-interleaved 64-bit lane with valid/ready
// handshakes; SERIAL selects one shared rotator (two compute cycles) or two
// rotators (one compute cycle).
module bi_rotl_seq
    import bi_pkg::*;
#(
    parameter bit SERIAL = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANE_W-1:0]  in_data,
    input  logic [SHIFT_W-1:0] in_shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANE_W-1:0]  out_data
);

    bi_state_t          state_q, state_d;
    bi_lane_t           data_q, data_d;
    bi_lane_t           res_q, res_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               out_valid_q, out_valid_d;
    logic               accept;
    bi_half_cfg_t       cfg_e, cfg_o;
    logic [HALF_W-1:0]  rot_e, rot_o;

    assign in_ready  = (state_q == IDLE) && !reset;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = res_q;

    // Rotator setup depends only on the captured shift, never on in_shift.
    assign cfg_e = bi_half_cfg(shift_q, 1'b0);
    assign cfg_o = bi_half_cfg(shift_q, 1'b1);

    generate
        if (SERIAL) begin : g_serial
            bi_half_cfg_t      cfg_s;
            logic [HALF_W-1:0] src_s;
            logic [HALF_W-1:0] rot_s;

            // Shared rotator works on the even half in CALC_E, odd half in CALC_O.
            always_comb begin
                cfg_s = (state_q == CALC_O) ? cfg_o : cfg_e;
                src_s = cfg_s.src_odd ? data_q.odd : data_q.even;
            end

            bi_rotl32 u_rot (.din(src_s), .amt(cfg_s.amt), .dout(rot_s));

            assign rot_e = rot_s;
            assign rot_o = rot_s;
        end else begin : g_parallel
            logic [HALF_W-1:0] src_e;
            logic [HALF_W-1:0] src_o;

            // Independent source selection for the two dedicated rotators.
            always_comb begin
                src_e = cfg_e.src_odd ? data_q.odd : data_q.even;
                src_o = cfg_o.src_odd ? data_q.odd : data_q.even;
            end

            bi_rotl32 u_rot_e (.din(src_e), .amt(cfg_e.amt), .dout(rot_e));
            bi_rotl32 u_rot_o (.din(src_o), .amt(cfg_o.amt), .dout(rot_o));
        end
    endgenerate

    // Next-state, capture and result-assembly logic.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        shift_d  = shift_q;
        res_d    = res_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = in_data;
                    shift_d = in_shift;
                    if (SERIAL) state_d = CALC_E;
                    else        state_d = CALC_O;
                end
            end
            CALC_E: begin
                res_d.even = rot_e;
                state_d    = CALC_O;
            end
            CALC_O: begin
                res_d.odd = rot_o;
                if (!SERIAL) res_d.even = rot_e;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            shift_q     <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            shift_q     <= shift_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_bi_rotl_seq.sv
// Scoreboard bench for bi_rotl_seq: index 0 is SERIAL=0, index 1 is SERIAL=1.
module tb_bi_rotl_seq;

    typedef struct {
        logic [63:0] exp;
        logic [63:0] din;
        logic [5:0]  n;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [63:0] in_data   [2];
    logic [5:0]  in_shift  [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [63:0] out_data  [2];
    logic        rdy_fix   [2];
    logic        rdy_rnd_en[2];
    logic        rdy_bit   [2];

    ent_t q0[$];
    ent_t q1[$];
    ent_t e0, e1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign out_ready[0] = rdy_rnd_en[0] ? rdy_bit[0] : rdy_fix[0];
    assign out_ready[1] = rdy_rnd_en[1] ? rdy_bit[1] : rdy_fix[1];

    bi_rotl_seq #(.SERIAL(1'b0)) u_par (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_shift(in_shift[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0])
    );

    bi_rotl_seq #(.SERIAL(1'b1)) u_ser (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_shift(in_shift[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1])
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] deint(input logic [63:0] x);
        logic [63:0] v;
        for (int i = 0; i < 32; i++) begin
            v[2*i]   = x[i];
            v[2*i+1] = x[32+i];
        end
        return v;
    endfunction

    function automatic logic [63:0] inter(input logic [63:0] v);
        logic [63:0] x;
        for (int i = 0; i < 32; i++) begin
            x[i]    = v[2*i];
            x[32+i] = v[2*i+1];
        end
        return x;
    endfunction

    function automatic logic [63:0] rotl64(input logic [63:0] v, input logic [5:0] n);
        logic [127:0] t;
        t = {v, v} << n;
        return t[127:64];
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] v, input logic [5:0] n);
        logic [127:0] t;
        t = {v, v} >> n;
        return t[63:0];
    endfunction

    function automatic logic [63:0] model(input logic [63:0] d, input logic [5:0] n);
        return inter(rotl64(deint(d), n));
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!reset && out_valid[0] && out_ready[0]) begin
            if (q0.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_out_par: got %h, required no output", out_data[0]);
            end else begin
                e0 = q0.pop_front();
                chk("data_par", out_data[0], e0.exp);
                chk("roundtrip_par", rotr64(deint(out_data[0]), e0.n), deint(e0.din));
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid[1] && out_ready[1]) begin
            if (q1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_out_ser: got %h, required no output", out_data[1]);
            end else begin
                e1 = q1.pop_front();
                chk("data_ser", out_data[1], e1.exp);
                chk("roundtrip_ser", rotr64(deint(out_data[1]), e1.n), deint(e1.din));
            end
        end
    end

    // Random consumer readiness, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        rdy_bit[0] = $urandom_range(0, 1) == 1;
        rdy_bit[1] = $urandom_range(0, 1) == 1;
    end

    // ---------------- stimulus ----------------
    // Called just after a rising edge. Presents a request, waits for acceptance,
    // queues the expected result, and optionally measures edges until out_valid
    // (the accept edge counts as the first).
    task automatic send(input int s, input logic [63:0] d, input logic [5:0] n,
                        input logic [63:0] expv, input bit wait_out, input int exp_lat);
        int   guard;
        int   lat;
        ent_t e;
        guard       = 0;
        in_data[s]  = d;
        in_shift[s] = n;
        in_valid[s] = 1'b1;
        while (!in_ready[s] && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready[s]) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got in_ready=0, required 1 within 100 cycles");
            in_valid[s] = 1'b0;
            return;
        end
        e.exp = expv; e.din = d; e.n = n;
        if (s == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clk); #1;
        in_valid[s] = 1'b0;
        in_data[s]  = {$urandom, $urandom};
        in_shift[s] = 6'($urandom);
        lat = 1;
        if (wait_out) begin
            while (!out_valid[s] && lat < 20) begin
                chk("in_ready_busy", 64'(in_ready[s]), 64'd0);
                @(posedge clk); #1;
                lat++;
            end
            chk("latency", 64'(lat), 64'(exp_lat));
        end
    endtask

    task automatic drain(input int s);
        int guard;
        guard = 0;
        while (((s == 0) ? q0.size() : q1.size()) != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("drain", 64'((s == 0) ? q0.size() : q1.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] d;
        logic [5:0]  n;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_data[i] = '0; in_shift[i] = '0;
            rdy_fix[i] = 1'b1; rdy_rnd_en[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_out_valid", 64'(out_valid[i]), 64'd0);
            chk("rst_out_data", out_data[i], 64'd0);
            chk("rst_in_ready", 64'(in_ready[i]), 64'd0);
        end
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready_par", 64'(in_ready[0]), 64'd1);
        chk("post_rst_in_ready_ser", 64'(in_ready[1]), 64'd1);

        // Directed vectors, SERIAL=1
        send(1, 64'h0000_0000_0000_0001, 6'd1,  64'h0000_0001_0000_0000, 1, 3);
        send(1, 64'h0000_0000_0000_0001, 6'd2,  64'h0000_0000_0000_0002, 1, 3);
        send(1, 64'h0000_0001_0000_0000, 6'd63, 64'h0000_0000_0000_0001, 1, 3);
        send(1, 64'hDEAD_BEEF_0123_4567, 6'd0,  64'hDEAD_BEEF_0123_4567, 1, 3);
        send(1, 64'h0000_0000_0000_0001, 6'd62, 64'h0000_0000_8000_0000, 1, 3);
        drain(1);

        // Directed vectors, SERIAL=0
        send(0, 64'h0000_0000_0000_0001, 6'd1,  64'h0000_0001_0000_0000, 1, 2);
        send(0, 64'h0000_0001_0000_0000, 6'd63, 64'h0000_0000_0000_0001, 1, 2);
        send(0, 64'h0000_0000_8000_0000, 6'd63, 64'h4000_0000_0000_0000, 1, 2);
        send(0, 64'hDEAD_BEEF_0123_4567, 6'd0,  64'hDEAD_BEEF_0123_4567, 1, 2);
        drain(0);

        // Backpressure on SERIAL=1
        rdy_fix[1] = 1'b0;
        send(1, 64'h0000_0003_0000_0005, 6'd4, 64'h0000_000C_0000_0014, 1, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid[1]), 64'd1);
            chk("bp_out_data", out_data[1], 64'h0000_000C_0000_0014);
            chk("bp_in_ready", 64'(in_ready[1]), 64'd0);
        end
        @(posedge clk); #1;
        rdy_fix[1] = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 64'(in_ready[1]), 64'd1);
        chk("bp_release_out_valid", 64'(out_valid[1]), 64'd0);

        // Reset while the shared rotator is in CALC_E
        send(1, 64'hFFFF_0000_1234_5678, 6'd3, 64'h0, 0, 0);
        void'(q1.pop_back());
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 64'(out_valid[1]), 64'd0);
        chk("midrst_out_data", out_data[1], 64'd0);
        chk("midrst_in_ready", 64'(in_ready[1]), 64'd0);
        reset = 1'b0;
        #1;
        chk("midrst_idle", 64'(in_ready[1]), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_output", 64'(out_valid[1]), 64'd0);
        end
        @(posedge clk); #1;
        send(1, 64'h0000_0000_0000_0001, 6'd5, 64'h0000_0004_0000_0000, 1, 3);
        drain(1);

        // Random equivalence with random consumer readiness
        for (int s = 0; s < 2; s++) begin
            rdy_rnd_en[s] = 1'b1;
            for (int i = 0; i < 1500; i++) begin
                d = {$urandom, $urandom};
                n = 6'($urandom);
                send(s, d, n, model(d, n), 1, (s == 0) ? 2 : 3);
            end
            rdy_rnd_en[s] = 1'b0;
            drain(s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
